// File: rtl/hamming_secded_decoder.sv
// Hamming SECDED decoder: two-stage pipeline with valid/ready handshake.
// Stage 1 registers the codeword with its syndrome and overall parity.
// Stage 2 registers the corrected data and the error classification.
// Saturating counters track delivered corrected and uncorrectable results.
module hamming_secded_decoder #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  // Smallest P with 2^P >= DATA_W+P+1, unrolled over the legal range 4..120
  localparam int P  = (DATA_W <= 4)  ? 3 :
                      (DATA_W <= 11) ? 4 :
                      (DATA_W <= 26) ? 5 :
                      (DATA_W <= 57) ? 6 : 7,
  localparam int CW = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_cw,
  input  logic              ecc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_single,
  output logic              out_double,
  output logic [P-1:0]      out_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  // Number of Hamming positions (data + parity), excluding the overall bit
  localparam int N = DATA_W + P;
  localparam logic [P-1:0] SYN_MAX = N[P-1:0];

  logic              advance;
  logic              fire;

  logic              s1_valid_q;
  logic [N-1:0]      s1_cw_q;
  logic [P-1:0]      s1_syn_q;
  logic              s1_ovr_q;
  logic              s1_ecc_q;

  logic [P-1:0]      syn_d;
  logic              ovr_d;

  logic [N-1:0]      fixed;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_single_q, out_single_d;
  logic              out_double_q, out_double_d;
  logic [P-1:0]      out_pos_q, out_pos_d;

  logic [CNT_W-1:0]  corr_cnt_q, uncorr_cnt_q;

  assign advance = !out_valid_q || out_ready;
  assign fire    = out_valid_q && out_ready;

  // Syndrome: XOR of the position indices of every set bit; ovr: overall parity
  always_comb begin
    syn_d = '0;
    for (int unsigned j = 1; j <= N; j++) begin
      if (in_cw[j-1]) syn_d = syn_d ^ j[P-1:0];
    end
    ovr_d = ^in_cw;
  end

  // Stage 1 register: codeword, syndrome, overall parity and mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s1_ovr_q   <= 1'b0;
      s1_ecc_q   <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_cw_q    <= in_cw[N-1:0];
      s1_syn_q   <= syn_d;
      s1_ovr_q   <= ovr_d;
      s1_ecc_q   <= ecc_en;
    end
  end

  // Classify the error, flip the indicated position and extract data bits
  always_comb begin
    int unsigned k;
    fixed        = s1_cw_q;
    out_single_d = 1'b0;
    out_double_d = 1'b0;
    out_pos_d    = '0;
    out_data_d   = '0;
    k            = 0;
    if (s1_ecc_q) begin
      out_pos_d = s1_syn_q;
      if (s1_ovr_q) begin
        if (s1_syn_q == '0) begin
          out_single_d = 1'b1;
        end else if (s1_syn_q <= SYN_MAX) begin
          out_single_d = 1'b1;
          for (int unsigned j = 1; j <= N; j++) begin
            if (j[P-1:0] == s1_syn_q) fixed[j-1] = !fixed[j-1];
          end
        end else begin
          out_double_d = 1'b1;
        end
      end else if (s1_syn_q != '0) begin
        out_double_d = 1'b1;
      end
    end
    for (int unsigned j = 1; j <= N; j++) begin
      if ((j & (j - 1)) != 0) begin
        out_data_d[k] = fixed[j-1];
        k = k + 1;
      end
    end
  end

  // Stage 2 register: holds the result while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_single_q <= 1'b0;
      out_double_q <= 1'b0;
      out_pos_q    <= '0;
    end else if (advance) begin
      out_valid_q  <= s1_valid_q;
      out_data_q   <= out_data_d;
      out_single_q <= out_single_d;
      out_double_q <= out_double_d;
      out_pos_q    <= out_pos_d;
    end
  end

  // Saturating event counters; clear takes priority over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (cnt_clr) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (fire) begin
      if (out_single_q && (corr_cnt_q != '1))   corr_cnt_q   <= corr_cnt_q + 1'b1;
      if (out_double_q && (uncorr_cnt_q != '1)) uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
    end
  end

  assign in_ready   = advance;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_single = out_single_q;
  assign out_double = out_double_q;
  assign out_pos    = out_pos_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule
